action_merge: RTL and testbench

Collects the per-packet results of the three parallel lookup stages and emits one merged action per packet to the output-port/action-apply stage. The stages are the vport default-forwarding lookup, the exact-match lookup and the wildcard lookup. Lookups have different latencies, so each result stream is buffered in its own FIFO. Entries are popped in lockstep, one per source per packet, and resolved by fixed priority: source 0 (vport) is highest, then 1 (exact), then 2 (wildcard).

---
 rtl/of_pkg.sv | 24 ++
 rtl/action_fifo.sv | 49 ++++
 rtl/action_merge.sv | 123 ++++++++++++
 tb/tb_action_merge.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/of_pkg.sv
// Shared lookup-pipeline types: action record layout, action type codes and the no-hit source marker.
package of_pkg;

    localparam int C_OUT_PORT_WIDTH   = 8;
    localparam int C_MATCH_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        ACT_FORWARD = 2'd0,
        ACT_DROP    = 2'd1,
        ACT_MIRROR  = 2'd2,
        ACT_TO_CPU  = 2'd3
    } action_type_e;

    localparam logic [1:0] NO_SOURCE = 2'd3;

    typedef struct packed {
        logic                          match;
        logic [C_OUT_PORT_WIDTH-1:0]   port;
        logic [C_OUT_PORT_WIDTH-1:0]   vport;
        logic [1:0]                    act_type;
        logic [C_MATCH_ADDR_WIDTH-1:0] match_addr;
    } action_t;

endpackage

// File: rtl/action_fifo.sv
// Single-clock FIFO of action records; head is visible the cycle after the write (no bypass).
// Caller qualifies push/pop: push only when not full or popping, pop only when not empty.
module action_fifo
    import of_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  action_t       push_data,
    input  logic          pop,
    output action_t       head,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    action_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/action_merge.sv
// Merges one result per packet from vport/exact/wildcard lookups by fixed priority; 2-cycle latency from last push.
// Output register holds until out_ready; in_almost_full asks the tuple generator to stall, excess pushes are dropped and flagged.
module action_merge
    import of_pkg::*;
#(
    parameter int C_FIFO_DEPTH  = 8,
    parameter int C_ALMOST_FULL = 6
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [2:0]                           in_valid,
    input  logic [2:0]                           in_match,
    input  logic [2:0][C_OUT_PORT_WIDTH-1:0]     in_port,
    input  logic [2:0][C_OUT_PORT_WIDTH-1:0]     in_vport,
    input  logic [2:0][1:0]                      in_type,
    input  logic [2:0][C_MATCH_ADDR_WIDTH-1:0]   in_match_addr,
    output logic                                 in_almost_full,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_match,
    output logic [C_OUT_PORT_WIDTH-1:0]          out_port,
    output logic [C_OUT_PORT_WIDTH-1:0]          out_vport,
    output logic [1:0]                           out_type,
    output logic [C_MATCH_ADDR_WIDTH-1:0]        out_match_addr,
    output logic [1:0]                           out_source,
    output logic [2:0]                           overflow,
    output logic [31:0]                          miss_count
);

    localparam int            AW     = $clog2(C_FIFO_DEPTH);
    localparam logic [AW:0]   AF_LVL = (AW+1)'(C_ALMOST_FULL);

    action_t          head [3];
    logic [2:0]       empty;
    logic [2:0]       full;
    logic [2:0]       push;
    logic [AW:0]      count [3];
    logic [2:0][AW:0] next_cnt;
    logic             pop;
    logic             af_next;

    // All sources advance together so packet alignment across FIFOs is preserved.
    assign pop = ~|empty && (!out_valid || out_ready);

    for (genvar g = 0; g < 3; g++) begin : g_src
        action_t rec;
        assign rec = '{match:      in_match[g],
                       port:       in_port[g],
                       vport:      in_vport[g],
                       act_type:   in_type[g],
                       match_addr: in_match_addr[g]};
        assign push[g]     = in_valid[g] && (!full[g] || pop);
        assign next_cnt[g] = count[g] + (AW+1)'(push[g]) - (AW+1)'(pop);

        action_fifo #(.DEPTH(C_FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[g]),
            .push_data (rec),
            .pop       (pop),
            .head      (head[g]),
            .empty     (empty[g]),
            .full      (full[g]),
            .count     (count[g])
        );
    end

    always_comb begin
        af_next = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (next_cnt[i] >= AF_LVL) af_next = 1'b1;
        end
    end

    action_t    win;
    logic [1:0] win_src;
    logic       hit;

    // Scan from lowest priority upward so the lowest hitting index is written last.
    always_comb begin
        win     = '0;
        win_src = NO_SOURCE;
        hit     = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            if (head[i].match) begin
                win     = head[i];
                win_src = 2'(i);
                hit     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_match      <= 1'b0;
            out_port       <= '0;
            out_vport      <= '0;
            out_type       <= '0;
            out_match_addr <= '0;
            out_source     <= '0;
            miss_count     <= '0;
            overflow       <= '0;
            in_almost_full <= 1'b0;
        end else begin
            overflow       <= overflow | (in_valid & full & {3{~pop}});
            in_almost_full <= af_next;
            if (pop) begin
                out_valid      <= 1'b1;
                out_match      <= hit;
                out_port       <= win.port;
                out_vport      <= win.vport;
                out_type       <= win.act_type;
                out_match_addr <= win.match_addr;
                out_source     <= win_src;
                if (!hit) miss_count <= miss_count + 32'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_action_merge.sv
// Bench for action_merge: vector table, directed multi-cycle sequences and a randomized stream against a queue model.
module tb_action_merge;
    import of_pkg::*;

    localparam int PW = C_OUT_PORT_WIDTH;
    localparam int MW = C_MATCH_ADDR_WIDTH;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [2:0]           in_valid, in_match;
    logic [2:0][PW-1:0]   in_port, in_vport;
    logic [2:0][1:0]      in_type;
    logic [2:0][MW-1:0]   in_match_addr;
    logic                 in_almost_full, out_valid, out_ready, out_match;
    logic [PW-1:0]        out_port, out_vport;
    logic [1:0]           out_type, out_source;
    logic [MW-1:0]        out_match_addr;
    logic [2:0]           overflow;
    logic [31:0]          miss_count;

    always #5 clk = ~clk;

    action_merge #(.C_FIFO_DEPTH(8), .C_ALMOST_FULL(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_match(in_match),
        .in_port(in_port), .in_vport(in_vport), .in_type(in_type),
        .in_match_addr(in_match_addr), .in_almost_full(in_almost_full),
        .out_valid(out_valid), .out_ready(out_ready), .out_match(out_match),
        .out_port(out_port), .out_vport(out_vport), .out_type(out_type),
        .out_match_addr(out_match_addr), .out_source(out_source),
        .overflow(overflow), .miss_count(miss_count)
    );

    typedef struct packed {
        logic          match;
        logic [PW-1:0] port;
        logic [PW-1:0] vport;
        logic [1:0]    typ;
        logic [MW-1:0] addr;
        logic [1:0]    src;
    } res_t;

    typedef struct packed {
        action_t r0, r1, r2;
        res_t    exp;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t out_now();
        return {out_match, out_port, out_vport, out_type, out_match_addr, out_source};
    endfunction

    function automatic action_t mk(input logic m, input logic [PW-1:0] p, input logic [PW-1:0] v,
                                   input logic [1:0] t, input logic [MW-1:0] a);
        return '{match: m, port: p, vport: v, act_type: t, match_addr: a};
    endfunction

    // Reference: first source in priority order with a hit supplies the action, otherwise an all-zero miss.
    function automatic res_t model(input action_t r0, input action_t r1, input action_t r2);
        action_t r [3];
        r[0] = r0; r[1] = r1; r[2] = r2;
        for (int i = 0; i < 3; i++)
            if (r[i].match) return {1'b1, r[i].port, r[i].vport, r[i].act_type, r[i].match_addr, 2'(i)};
        return {1'b0, {PW{1'b0}}, {PW{1'b0}}, 2'b00, {MW{1'b0}}, NO_SOURCE};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = '0; in_match = '0; in_port = '0;
        in_vport = '0; in_type = '0; in_match_addr = '0;
    endtask

    task automatic set_src(input int i, input action_t r);
        in_valid[i]      = 1'b1;
        in_match[i]      = r.match;
        in_port[i]       = r.port;
        in_vport[i]      = r.vport;
        in_type[i]       = r.act_type;
        in_match_addr[i] = r.match_addr;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    vec_t    vt [6];
    action_t sent [3][$];
    res_t    miss_res;
    int      exp_miss;

    initial begin
        idle_inputs();
        out_ready = 1'b0;
        miss_res  = {1'b0, {PW{1'b0}}, {PW{1'b0}}, 2'b00, {MW{1'b0}}, 2'd3};

        // Reset state
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_fields", out_now(), 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_miss", miss_count, 0);
        chk("rst_afull", in_almost_full, 0);

        // Single-packet vectors, all sources in the same cycle
        vt[0] = '{r0: mk(1, 8'h04, 8'h00, 2'd0, 8'h02), r1: mk(0, 8'h80, 8'h11, 2'd1, 8'h09),
                  r2: mk(0, 8'h40, 8'h22, 2'd2, 8'h0a), exp: {1'b1, 8'h04, 8'h00, 2'd0, 8'h02, 2'd0}};
        vt[1] = '{r0: mk(0, 8'h80, 8'hff, 2'd3, 8'hee), r1: mk(1, 8'h10, 8'h02, 2'd1, 8'h05),
                  r2: mk(1, 8'h01, 8'h00, 2'd2, 8'h07), exp: {1'b1, 8'h10, 8'h02, 2'd1, 8'h05, 2'd1}};
        vt[2] = '{r0: mk(0, 8'h08, 8'h08, 2'd1, 8'h01), r1: mk(0, 8'h04, 8'h04, 2'd1, 8'h02),
                  r2: mk(1, 8'h20, 8'h40, 2'd3, 8'h33), exp: {1'b1, 8'h20, 8'h40, 2'd3, 8'h33, 2'd2}};
        vt[3] = '{r0: mk(0, 8'h02, 8'h12, 2'd2, 8'h44), r1: mk(0, 8'h01, 8'h34, 2'd3, 8'h55),
                  r2: mk(0, 8'h80, 8'h56, 2'd1, 8'h66), exp: {1'b0, 8'h00, 8'h00, 2'd0, 8'h00, 2'd3}};
        vt[4] = '{r0: mk(1, 8'h01, 8'h0f, 2'd2, 8'haa), r1: mk(1, 8'h02, 8'hf0, 2'd1, 8'hbb),
                  r2: mk(1, 8'h04, 8'h3c, 2'd3, 8'hcc), exp: {1'b1, 8'h01, 8'h0f, 2'd2, 8'haa, 2'd0}};
        vt[5] = '{r0: mk(1, 8'h80, 8'hff, 2'd3, 8'hff), r1: mk(0, 8'h00, 8'h00, 2'd0, 8'h00),
                  r2: mk(1, 8'h01, 8'h01, 2'd1, 8'h01), exp: {1'b1, 8'h80, 8'hff, 2'd3, 8'hff, 2'd0}};
        exp_miss   = 0;
        out_ready  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_src(0, vt[k].r0); set_src(1, vt[k].r1); set_src(2, vt[k].r2);
            chk($sformatf("tbl%0d_c0_valid", k), out_valid, 0);
            step();
            idle_inputs();
            chk($sformatf("tbl%0d_c1_valid", k), out_valid, 0);
            step();
            chk($sformatf("tbl%0d_c2_valid", k), out_valid, 1);
            chk($sformatf("tbl%0d_c2_fields", k), out_now(), vt[k].exp);
            if (!vt[k].exp.match) exp_miss++;
            step();
        end
        chk("tbl_miss_count", miss_count, 32'(exp_miss));

        // Source 2 lags source 1 by five cycles
        set_src(0, mk(0, 8'h00, 8'h00, 2'd0, 8'h00));
        set_src(1, mk(1, 8'h10, 8'h20, 2'd1, 8'h30));
        step();
        idle_inputs();
        for (int c = 1; c < 5; c++) begin
            chk($sformatf("lag_wait%0d_valid", c), out_valid, 0);
            step();
        end
        set_src(2, mk(1, 8'h01, 8'h02, 2'd2, 8'h03));
        step();
        idle_inputs();
        chk("lag_c1_valid", out_valid, 0);
        step();
        chk("lag_c2_valid", out_valid, 1);
        chk("lag_c2_fields", out_now(), {1'b1, 8'h10, 8'h20, 2'd1, 8'h30, 2'd1});
        step();

        // Three consecutive all-miss packets
        begin
            int n_out = 0;
            for (int c = 0; c < 8; c++) begin
                idle_inputs();
                if (c < 3)
                    for (int i = 0; i < 3; i++) set_src(i, mk(0, PW'(c + 1), PW'(i), 2'(i), MW'(c)));
                if (out_valid && out_ready) begin
                    chk($sformatf("miss3_out%0d", n_out), out_now(), miss_res);
                    n_out++;
                end
                step();
            end
            exp_miss += 3;
            chk("miss3_count", n_out, 3);
            chk("miss3_miss_count", miss_count, 32'(exp_miss));
        end

        // Fill FIFO 0 alone with output stalled, then overflow it
        out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            idle_inputs();
            set_src(0, mk(1, PW'(k), 8'h00, 2'd0, MW'(k)));
            step();
            if (k == 5) chk("fill5_afull", in_almost_full, 0);
            if (k == 6) chk("fill6_afull", in_almost_full, 1);
            if (k == 8) chk("fill8_overflow", overflow, 0);
        end
        idle_inputs();
        chk("fill9_overflow", overflow, 3'b001);
        chk("fill9_valid", out_valid, 0);
        begin
            int n_out = 0;
            out_ready = 1'b1;
            for (int c = 0; c < 16; c++) begin
                idle_inputs();
                if (c < 8) begin
                    set_src(1, mk(0, 8'h00, 8'h00, 2'd0, 8'h00));
                    set_src(2, mk(0, 8'h00, 8'h00, 2'd0, 8'h00));
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    chk($sformatf("drain_out%0d", n_out), out_now(),
                        {1'b1, PW'(n_out), 8'h00, 2'd0, MW'(n_out), 2'd0});
                end
                step();
            end
            chk("drain_count", n_out, 8);
            chk("drain_afull", in_almost_full, 0);
            chk("drain_overflow_sticky", overflow, 3'b001);
        end

        // Randomized stream with toggling, then random, out_ready
        idle_inputs();
        do_reset();
        chk("rst2_overflow", overflow, 0);
        begin
            int      n_pkt = 40;
            int      pushed [3];
            int      got = 0;
            int      cyc = 0;
            int      rmiss = 0;
            logic    was_stalled = 1'b0;
            res_t    held = '0;
            res_t    exp;
            action_t r;
            for (int i = 0; i < 3; i++) begin pushed[i] = 0; sent[i].delete(); end
            while (got < n_pkt && cyc < 3000) begin
                idle_inputs();
                for (int i = 0; i < 3; i++) begin
                    if (pushed[i] < n_pkt && pushed[i] - got < 6 && $urandom_range(0, 3) != 0) begin
                        r = mk(1'($urandom_range(0, 1)), PW'($urandom), PW'($urandom),
                               2'($urandom), MW'($urandom));
                        sent[i].push_back(r);
                        set_src(i, r);
                        pushed[i]++;
                    end
                end
                out_ready = (cyc < 40) ? !cyc[0] : ($urandom_range(0, 1) == 1);
                if (was_stalled) begin
                    chk("stall_hold_valid", out_valid, 1);
                    chk("stall_hold_fields", out_now(), held);
                end
                if (out_valid && out_ready) begin
                    if (got < sent[0].size() && got < sent[1].size() && got < sent[2].size()) begin
                        exp = model(sent[0][got], sent[1][got], sent[2][got]);
                        chk($sformatf("stream_out%0d", got), out_now(), exp);
                        if (!exp.match) rmiss++;
                    end else begin
                        chk("stream_extra_output", got, n_pkt);
                    end
                    got++;
                end
                was_stalled = out_valid && !out_ready;
                held        = out_now();
                step();
                cyc++;
            end
            chk("stream_complete", got, n_pkt);
            idle_inputs();
            out_ready = 1'b1;
            step();
            step();
            chk("stream_no_extra", out_valid, 0);
            chk("stream_miss_count", miss_count, 32'(rmiss));
            chk("stream_overflow", overflow, 0);
        end

        // Asynchronous reset with packets buffered and the output occupied
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            for (int i = 0; i < 3; i++) set_src(i, mk(0, 8'h55, 8'haa, 2'd1, MW'(k)));
            step();
        end
        idle_inputs();
        step();
        step();
        chk("prerst_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_fields", out_now(), 0);
        chk("arst_miss", miss_count, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_afull", in_almost_full, 0);
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        begin
            int spurious = 0;
            for (int c = 0; c < 8; c++) begin
                step();
                if (out_valid) spurious++;
            end
            chk("postrst_spurious", spurious, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
